// File: rtl/breakout_renderer_pkg.sv
// breakout_renderer_pkg
// Purpose: shared game geometry, colour constants and the stage-1 record type
//          used by the breakout pixel renderer.
// Ports:   none (package).
package breakout_renderer_pkg;

    // Screen tiles are 8x8 pixels; walls are one tile thick.
    localparam int unsigned ballSizePixel     = 8;
    localparam int unsigned paddleLengthPixel = 64;
    localparam int unsigned paddleYPixel      = 448;
    localparam int unsigned paddleHeightPixel = 8;

    localparam logic [6:0]  leftWallXTile  = 7'd0;
    localparam logic [6:0]  rightWallXTile = 7'd79;
    localparam logic [6:0]  ceilingYTile   = 7'd0;

    localparam int unsigned blockOriginXPixel = 128;
    localparam int unsigned blockOriginYPixel = 64;
    localparam int unsigned blockWidthPixel   = 32;
    localparam int unsigned blockHeightPixel  = 16;
    localparam int unsigned blockColumns      = 12;
    localparam int unsigned blockRows         = 6;
    localparam int unsigned blockCount        = blockColumns * blockRows;

    localparam logic [7:0] ballColor       = 8'hFC;
    localparam logic [7:0] paddleColor     = 8'hFF;
    localparam logic [7:0] wallColor       = 8'hB6;
    localparam logic [7:0] backgroundColor = 8'h00;

    // Everything stage 1 hands to stage 2 for one pixel.
    typedef struct packed {
        logic       valid;
        logic       ball;
        logic       paddle;
        logic       wall;
        logic       inRegion;
        logic       gap;
        logic [2:0] row;
        logic [6:0] blockIndex;
    } hitFlags_t;

    // Block colour by row, top to bottom.
    function automatic logic [7:0] rowColor(input logic [2:0] row);
        case (row)
            3'd0:    rowColor = 8'hE0;
            3'd1:    rowColor = 8'hEC;
            3'd2:    rowColor = 8'hFC;
            3'd3:    rowColor = 8'h1C;
            3'd4:    rowColor = 8'h1F;
            3'd5:    rowColor = 8'hE3;
            default: rowColor = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/breakout_renderer_if.sv
// breakout_renderer_if
// Purpose: bundles the pixel stream, the game-state inputs and the colour
//          output of the renderer.
// Modports:
//   master - VGA timing / game logic side: drives pixel and game state,
//            receives START_UPDATE and the colour stream.
//   slave  - renderer side.
interface breakout_renderer_if;
    logic [9:0]  PIXEL_X;
    logic [9:0]  PIXEL_Y;
    logic        PIXEL_VALID;
    logic        NEW_FRAME;
    logic [9:0]  PADDLE_X_PIXEL;
    logic [9:0]  BALL_X_PIXEL;
    logic [9:0]  BALL_Y_PIXEL;
    logic [71:0] BLOCK_STATE;
    logic        START_UPDATE;
    logic [7:0]  COLOR;
    logic        COLOR_VALID;

    modport master (
        output PIXEL_X, PIXEL_Y, PIXEL_VALID, NEW_FRAME,
               PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, BLOCK_STATE,
        input  START_UPDATE, COLOR, COLOR_VALID
    );

    modport slave (
        input  PIXEL_X, PIXEL_Y, PIXEL_VALID, NEW_FRAME,
               PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, BLOCK_STATE,
        output START_UPDATE, COLOR, COLOR_VALID
    );
endinterface

// File: rtl/breakout_renderer.sv
// breakout_renderer
// Purpose: per-pixel RGB332 colour generator. Snapshots paddle/ball/block
//          state on NEW_FRAME, pulses START_UPDATE one cycle later, and maps
//          each pixel coordinate to a colour through a 2-stage pipeline.
// Ports:
//   CLK    - pixel clock (shared with game logic)
//   RST_N  - asynchronous active-low reset
//   bus    - breakout_renderer_if.slave: pixel stream in, game state in,
//            START_UPDATE / COLOR / COLOR_VALID out (COLOR_VALID is
//            PIXEL_VALID delayed by 2 cycles).
module breakout_renderer
    import breakout_renderer_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST_N,
    breakout_renderer_if.slave   bus
);

    logic [9:0]  paddleSnap;
    logic [9:0]  ballXSnap;
    logic [9:0]  ballYSnap;
    logic [71:0] blockSnap;

    hitFlags_t   stage1Next;
    hitFlags_t   stage1;
    logic [7:0]  colorNext;

    logic [10:0] x11;
    logic [10:0] y11;
    logic [10:0] dx;
    logic [10:0] dy;
    logic [3:0]  col;
    logic [2:0]  row;
    logic        inRegion;

    // Snapshot and START_UPDATE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            paddleSnap       <= '0;
            ballXSnap        <= '0;
            ballYSnap        <= '0;
            blockSnap        <= '0;
            bus.START_UPDATE <= 1'b0;
        end else begin
            bus.START_UPDATE <= bus.NEW_FRAME;
            if (bus.NEW_FRAME) begin
                paddleSnap <= bus.PADDLE_X_PIXEL;
                ballXSnap  <= bus.BALL_X_PIXEL;
                ballYSnap  <= bus.BALL_Y_PIXEL;
                blockSnap  <= bus.BLOCK_STATE;
            end
        end
    end

    // Stage 1: range tests. Upper bounds are 11-bit sums so objects near the
    // right/bottom edge do not wrap onto column/row 0; a negative dx/dy shows
    // up as bit 10 set and falls outside the block region.
    always_comb begin
        x11 = {1'b0, bus.PIXEL_X};
        y11 = {1'b0, bus.PIXEL_Y};
        dx  = x11 - 11'(blockOriginXPixel);
        dy  = y11 - 11'(blockOriginYPixel);
        col = dx[8:5];
        row = dy[6:4];
        inRegion = !dx[10] && (dx < 11'(blockColumns * blockWidthPixel)) &&
                   !dy[10] && (dy < 11'(blockRows * blockHeightPixel));

        stage1Next        = '0;
        stage1Next.valid  = bus.PIXEL_VALID;
        stage1Next.ball   = (x11 >= {1'b0, ballXSnap}) &&
                            (x11 <  {1'b0, ballXSnap} + 11'(ballSizePixel)) &&
                            (y11 >= {1'b0, ballYSnap}) &&
                            (y11 <  {1'b0, ballYSnap} + 11'(ballSizePixel));
        stage1Next.paddle = (x11 >= {1'b0, paddleSnap}) &&
                            (x11 <  {1'b0, paddleSnap} + 11'(paddleLengthPixel)) &&
                            (y11 >= 11'(paddleYPixel)) &&
                            (y11 <  11'(paddleYPixel + paddleHeightPixel));
        stage1Next.wall   = (bus.PIXEL_X[9:3] == leftWallXTile) ||
                            (bus.PIXEL_X[9:3] == rightWallXTile) ||
                            (bus.PIXEL_Y[9:3] == ceilingYTile);
        stage1Next.inRegion = inRegion;
        stage1Next.gap      = (dx[4:0] == 5'd31) || (dy[3:0] == 4'd15);
        stage1Next.row      = row;
        // Index forced to 0 outside the region so stage 2 never reads past bit 71.
        stage1Next.blockIndex = inRegion ?
            ({4'b0, row} * 7'(blockColumns) + {3'b0, col}) : 7'd0;
    end

    // Stage 2: block lookup and priority select.
    always_comb begin
        colorNext = backgroundColor;
        if (stage1.ball) begin
            colorNext = ballColor;
        end else if (stage1.paddle) begin
            colorNext = paddleColor;
        end else if (stage1.inRegion && !stage1.gap && blockSnap[stage1.blockIndex]) begin
            colorNext = rowColor(stage1.row);
        end else if (stage1.wall) begin
            colorNext = wallColor;
        end
        if (!stage1.valid) begin
            colorNext = 8'h00;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stage1          <= '0;
            bus.COLOR       <= 8'h00;
            bus.COLOR_VALID <= 1'b0;
        end else begin
            stage1          <= stage1Next;
            bus.COLOR       <= colorNext;
            bus.COLOR_VALID <= stage1.valid;
        end
    end

endmodule

// File: tb/tb_breakout_renderer.sv
// tb_breakout_renderer
// Purpose: self-checking bench for breakout_renderer. Inputs are driven and
//          outputs sampled 1 time unit after each rising CLK edge.
module tb_breakout_renderer;

    logic CLK;
    logic RST_N;
    int   passCount;
    int   checkCount;

    breakout_renderer_if bus ();

    breakout_renderer dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       valid;
        logic [7:0] expColor;
        logic       expValid;
    } vec_t;

    vec_t vecs[$];

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("FAIL %s: got %0h, required %0h", name, actual, expected);
    endtask

    task automatic checkPixel(input string name, input logic [9:0] x, input logic [9:0] y,
                              input logic valid, input logic [7:0] expColor, input logic expValid);
        bus.PIXEL_X     = x;
        bus.PIXEL_Y     = y;
        bus.PIXEL_VALID = valid;
        cyc();
        bus.PIXEL_VALID = 1'b0;
        cyc();
        check({name, ".color"}, 32'(bus.COLOR), 32'(expColor));
        check({name, ".valid"}, 32'(bus.COLOR_VALID), 32'(expValid));
    endtask

    task automatic newFrame(input string name);
        bus.NEW_FRAME = 1'b1;
        check({name, ".su_before"}, 32'(bus.START_UPDATE), 32'd0);
        cyc();
        bus.NEW_FRAME = 1'b0;
        check({name, ".su_pulse"}, 32'(bus.START_UPDATE), 32'd1);
        cyc();
        check({name, ".su_after"}, 32'(bus.START_UPDATE), 32'd0);
    endtask

    function automatic logic [71:0] blocks(input logic with0);
        logic [71:0] b;
        b = '0;
        b[0]  = with0;
        b[12] = 1'b1;
        b[25] = 1'b1;
        b[36] = 1'b1;
        b[48] = 1'b1;
        b[71] = 1'b1;
        return b;
    endfunction

    initial begin
        passCount  = 0;
        checkCount = 0;
        RST_N = 1'b0;
        bus.PIXEL_X = '0;
        bus.PIXEL_Y = '0;
        bus.PIXEL_VALID = 1'b0;
        bus.NEW_FRAME = 1'b0;
        bus.PADDLE_X_PIXEL = 10'd300;
        bus.BALL_X_PIXEL = 10'd100;
        bus.BALL_Y_PIXEL = 10'd200;
        bus.BLOCK_STATE = blocks(1'b1);

        // Frame-1 vectors: ball (100,200), paddle 300, blocks 0,12,25,36,48,71.
        vecs.push_back(vec_t'{10'd103, 10'd203, 1'b1, 8'hFC, 1'b1});
        vecs.push_back(vec_t'{10'd99,  10'd203, 1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd107, 10'd207, 1'b1, 8'hFC, 1'b1});
        vecs.push_back(vec_t'{10'd108, 10'd203, 1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd100, 10'd208, 1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd128, 10'd64,  1'b1, 8'hE0, 1'b1});
        vecs.push_back(vec_t'{10'd159, 10'd64,  1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd128, 10'd79,  1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd160, 10'd64,  1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd127, 10'd64,  1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd128, 10'd80,  1'b1, 8'hEC, 1'b1});
        vecs.push_back(vec_t'{10'd160, 10'd96,  1'b1, 8'hFC, 1'b1});
        vecs.push_back(vec_t'{10'd128, 10'd112, 1'b1, 8'h1C, 1'b1});
        vecs.push_back(vec_t'{10'd128, 10'd128, 1'b1, 8'h1F, 1'b1});
        vecs.push_back(vec_t'{10'd480, 10'd144, 1'b1, 8'hE3, 1'b1});
        vecs.push_back(vec_t'{10'd511, 10'd144, 1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd512, 10'd144, 1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd300, 10'd448, 1'b1, 8'hFF, 1'b1});
        vecs.push_back(vec_t'{10'd363, 10'd455, 1'b1, 8'hFF, 1'b1});
        vecs.push_back(vec_t'{10'd364, 10'd448, 1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd299, 10'd448, 1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd300, 10'd456, 1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd300, 10'd447, 1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd3,   10'd100, 1'b1, 8'hB6, 1'b1});
        vecs.push_back(vec_t'{10'd635, 10'd100, 1'b1, 8'hB6, 1'b1});
        vecs.push_back(vec_t'{10'd300, 10'd5,   1'b1, 8'hB6, 1'b1});
        vecs.push_back(vec_t'{10'd300, 10'd8,   1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd8,   10'd100, 1'b1, 8'h00, 1'b1});
        vecs.push_back(vec_t'{10'd103, 10'd203, 1'b0, 8'h00, 1'b0});

        // Reset state.
        cyc();
        cyc();
        check("rst.color", 32'(bus.COLOR), 32'h00);
        check("rst.valid", 32'(bus.COLOR_VALID), 32'd0);
        check("rst.su", 32'(bus.START_UPDATE), 32'd0);
        RST_N = 1'b1;
        cyc();

        // No snapshot yet: blocks absent, ball/paddle at 0.
        checkPixel("pre.ballpos", 10'd103, 10'd203, 1'b1, 8'h00, 1'b1);
        checkPixel("pre.block",   10'd128, 10'd64,  1'b1, 8'h00, 1'b1);
        checkPixel("pre.paddle",  10'd300, 10'd448, 1'b1, 8'h00, 1'b1);
        check("pre.su", 32'(bus.START_UPDATE), 32'd0);

        newFrame("nf1");
        foreach (vecs[i]) begin
            checkPixel($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].valid,
                       vecs[i].expColor, vecs[i].expValid);
        end

        // Game state changes without NEW_FRAME do not affect the frame.
        bus.BALL_X_PIXEL = 10'd400;
        bus.BLOCK_STATE  = '0;
        bus.PADDLE_X_PIXEL = 10'd0;
        checkPixel("hold.ball",   10'd103, 10'd203, 1'b1, 8'hFC, 1'b1);
        checkPixel("hold.block",  10'd128, 10'd64,  1'b1, 8'hE0, 1'b1);
        checkPixel("hold.paddle", 10'd300, 10'd448, 1'b1, 8'hFF, 1'b1);
        check("hold.su", 32'(bus.START_UPDATE), 32'd0);

        // Ball on top of paddle, block 0 cleared.
        bus.BALL_X_PIXEL   = 10'd300;
        bus.BALL_Y_PIXEL   = 10'd448;
        bus.PADDLE_X_PIXEL = 10'd300;
        bus.BLOCK_STATE    = blocks(1'b0);
        newFrame("nf2");
        checkPixel("prio.a",    10'd300, 10'd448, 1'b1, 8'hFC, 1'b1);
        checkPixel("prio.b",    10'd307, 10'd455, 1'b1, 8'hFC, 1'b1);
        checkPixel("prio.pad",  10'd308, 10'd448, 1'b1, 8'hFF, 1'b1);
        checkPixel("clr.block", 10'd128, 10'd64,  1'b1, 8'h00, 1'b1);
        checkPixel("keep.row1", 10'd128, 10'd80,  1'b1, 8'hEC, 1'b1);

        // NEW_FRAME while a pixel is in stage 1 input: that pixel uses the old
        // snapshot, the next one uses the new.
        bus.BALL_X_PIXEL = 10'd600;
        bus.NEW_FRAME    = 1'b1;
        bus.PIXEL_X      = 10'd300;
        bus.PIXEL_Y      = 10'd448;
        bus.PIXEL_VALID  = 1'b1;
        cyc();
        bus.NEW_FRAME = 1'b0;
        check("midnf.su", 32'(bus.START_UPDATE), 32'd1);
        cyc();
        bus.PIXEL_VALID = 1'b0;
        check("midnf.old", 32'(bus.COLOR), 32'hFC);
        check("midnf.su0", 32'(bus.START_UPDATE), 32'd0);
        cyc();
        check("midnf.new", 32'(bus.COLOR), 32'hFF);
        check("midnf.v", 32'(bus.COLOR_VALID), 32'd1);
        cyc();

        // Back-to-back NEW_FRAME pulses.
        bus.NEW_FRAME = 1'b1;
        cyc();
        check("b2b.su1", 32'(bus.START_UPDATE), 32'd1);
        cyc();
        bus.NEW_FRAME = 1'b0;
        check("b2b.su2", 32'(bus.START_UPDATE), 32'd1);
        cyc();
        check("b2b.su3", 32'(bus.START_UPDATE), 32'd0);

        // Ball near the right edge must not wrap.
        bus.BALL_X_PIXEL = 10'd1020;
        bus.BALL_Y_PIXEL = 10'd200;
        newFrame("nf3");
        checkPixel("wrap.in",   10'd1021, 10'd200, 1'b1, 8'hFC, 1'b1);
        checkPixel("wrap.low",  10'd1019, 10'd200, 1'b1, 8'h00, 1'b1);
        checkPixel("wrap.zero", 10'd2,    10'd200, 1'b1, 8'hB6, 1'b1);

        // Reset while streaming.
        bus.PIXEL_X     = 10'd1021;
        bus.PIXEL_Y     = 10'd200;
        bus.PIXEL_VALID = 1'b1;
        cyc();
        cyc();
        check("stream.color", 32'(bus.COLOR), 32'hFC);
        #1;
        RST_N = 1'b0;
        #1;
        check("arst.color", 32'(bus.COLOR), 32'h00);
        check("arst.valid", 32'(bus.COLOR_VALID), 32'd0);
        cyc();
        RST_N = 1'b1;
        bus.PIXEL_X = 10'd300;
        bus.PIXEL_Y = 10'd300;
        cyc();
        check("refill.v1", 32'(bus.COLOR_VALID), 32'd0);
        cyc();
        check("refill.v2", 32'(bus.COLOR_VALID), 32'd1);
        check("refill.color", 32'(bus.COLOR), 32'h00);
        bus.PIXEL_VALID = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
